// File: rtl/sc_loadclear_sequencer.sv
// Turns debounced active-low clear/load button levels into one-cycle active-low
// strobes for the register, with clear priority and a wrapping load-strobe count.
// Optional load auto-repeat while held: LOADCLEAR_SEQUENCER_AUTOREPEAT_EN.
module sc_loadclear_sequencer #(
    parameter int unsigned HOLD_CYCLES   = 25000000,
    parameter int unsigned REPEAT_CYCLES = 5000000,
    parameter int unsigned CNT_WIDTH     = 25,
    parameter int unsigned COUNT_WIDTH   = 8
) (
    input  logic                   sc_loadclear_sequencer_CLOCK_50,
    input  logic                   sc_loadclear_sequencer_RESET_InHigh,
    input  logic                   sc_loadclear_sequencer_clear_InLow,
    input  logic                   sc_loadclear_sequencer_load_InLow,
    output logic                   sc_loadclear_sequencer_clear_OutLow,
    output logic                   sc_loadclear_sequencer_load_OutLow,
    output logic                   sc_loadclear_sequencer_busy_Out,
    output logic [COUNT_WIDTH-1:0] sc_loadclear_sequencer_count_OutBUS
);

`ifdef LOADCLEAR_SEQUENCER_AUTOREPEAT_EN
    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        CLEAR_PULSE  = 3'd1,
        LOAD_PULSE   = 3'd2,
        RELEASE_WAIT = 3'd3,
        HOLD_WAIT    = 3'd4,
        REPEAT_PULSE = 3'd5,
        REPEAT_WAIT  = 3'd6
    } state_t;

    localparam logic [CNT_WIDTH-1:0] HOLD_LAST   = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(REPEAT_CYCLES - 1);
`else
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        CLEAR_PULSE  = 2'd1,
        LOAD_PULSE   = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // Timing parameters have no effect when auto-repeat is not built.
    localparam int unsigned unusedConfig = HOLD_CYCLES + REPEAT_CYCLES + CNT_WIDTH;
`endif

    logic   clk;
    logic   rst;
    logic   clearIn;
    logic   loadIn;
    logic   clearPrev;
    logic   loadPrev;
    logic   clearFall;
    logic   loadFall;
    state_t state;
    state_t nextState;
    logic   inLoadPulse;
    logic   clearNext;
    logic   loadNext;
    logic   busyNext;
    logic   clearOutReg;
    logic   loadOutReg;
    logic   busyReg;
    logic [COUNT_WIDTH-1:0] loadCount;

    assign clk     = sc_loadclear_sequencer_CLOCK_50;
    assign rst     = sc_loadclear_sequencer_RESET_InHigh;
    assign clearIn = sc_loadclear_sequencer_clear_InLow;
    assign loadIn  = sc_loadclear_sequencer_load_InLow;

    // Previous samples reset high so a button held through reset still strobes once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clearPrev <= 1'b1;
            loadPrev  <= 1'b1;
        end else begin
            clearPrev <= clearIn;
            loadPrev  <= loadIn;
        end
    end

    assign clearFall = clearPrev & ~clearIn;
    assign loadFall  = loadPrev & ~loadIn;

`ifdef LOADCLEAR_SEQUENCER_AUTOREPEAT_EN
    logic [CNT_WIDTH-1:0] timer;

    // Timer runs only while staying in a wait state; any entry restarts it at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if ((state == HOLD_WAIT || state == REPEAT_WAIT) && nextState == state) begin
            timer <= timer + CNT_WIDTH'(1);
        end else begin
            timer <= '0;
        end
    end
`endif

    // Next-state logic; a clear fall preempts everything else.
    always_comb begin
        nextState = state;
        if (clearFall && state != CLEAR_PULSE) begin
            nextState = CLEAR_PULSE;
        end else begin
            case (state)
                IDLE: begin
                    if (loadFall) nextState = LOAD_PULSE;
                end
                CLEAR_PULSE: nextState = RELEASE_WAIT;
`ifdef LOADCLEAR_SEQUENCER_AUTOREPEAT_EN
                LOAD_PULSE: nextState = HOLD_WAIT;
`else
                LOAD_PULSE: nextState = RELEASE_WAIT;
`endif
                RELEASE_WAIT: begin
                    if (clearIn && loadIn) nextState = IDLE;
                end
`ifdef LOADCLEAR_SEQUENCER_AUTOREPEAT_EN
                HOLD_WAIT: begin
                    if (loadIn) nextState = IDLE;
                    else if (timer == HOLD_LAST) nextState = REPEAT_PULSE;
                end
                REPEAT_PULSE: nextState = REPEAT_WAIT;
                REPEAT_WAIT: begin
                    if (loadIn) nextState = IDLE;
                    else if (timer == REPEAT_LAST) nextState = REPEAT_PULSE;
                end
`endif
                default: nextState = IDLE;
            endcase
        end
    end

    // Output decode of the upcoming state, so the registered strobes align with it.
    always_comb begin
        inLoadPulse = 1'b0;
        clearNext   = (nextState != CLEAR_PULSE);
        busyNext    = (nextState != IDLE);
`ifdef LOADCLEAR_SEQUENCER_AUTOREPEAT_EN
        loadNext    = (nextState != LOAD_PULSE) && (nextState != REPEAT_PULSE);
        inLoadPulse = (state == LOAD_PULSE) || (state == REPEAT_PULSE);
`else
        loadNext    = (nextState != LOAD_PULSE);
        inLoadPulse = (state == LOAD_PULSE);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            clearOutReg <= 1'b1;
            loadOutReg  <= 1'b1;
            busyReg     <= 1'b0;
        end else begin
            state       <= nextState;
            clearOutReg <= clearNext;
            loadOutReg  <= loadNext;
            busyReg     <= busyNext;
        end
    end

    // Count advances after each load strobe and is zeroed after a clear strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loadCount <= '0;
        end else if (state == CLEAR_PULSE) begin
            loadCount <= '0;
        end else if (inLoadPulse) begin
            loadCount <= loadCount + COUNT_WIDTH'(1);
        end
    end

    assign sc_loadclear_sequencer_clear_OutLow = clearOutReg;
    assign sc_loadclear_sequencer_load_OutLow  = loadOutReg;
    assign sc_loadclear_sequencer_busy_Out     = busyReg;
    assign sc_loadclear_sequencer_count_OutBUS = loadCount;

endmodule

// File: tb/tb_sc_loadclear_sequencer.sv
// Bench for sc_loadclear_sequencer: directed scenarios plus random button activity,
// checked every cycle against a press-age model of the strobe schedule.
module tb_sc_loadclear_sequencer;

    localparam int HOLD = 8;
    localparam int REP  = 4;
`ifdef LOADCLEAR_SEQUENCER_AUTOREPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    localparam int M_IDLE    = 0;
    localparam int M_PRESS   = 1;
    localparam int M_RELEASE = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clrIn = 1'b1;
    logic       ldIn = 1'b1;
    logic       clrOut;
    logic       ldOut;
    logic       busy;
    logic [7:0] count;

    int vectors = 0;
    int errs = 0;
    int clrSeen = 0;
    int ldSeen = 0;

    // Model: mode of the current press, edges since its first strobe, pending strobes.
    int         mMode;
    int         mAge;
    bit         mPrevClr;
    bit         mPrevLd;
    bit         mClr;
    bit         mLd;
    logic [7:0] mCount;

    always #5 clk = ~clk;

    sc_loadclear_sequencer #(
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REP),
        .CNT_WIDTH    (4),
        .COUNT_WIDTH  (8)
    ) dut (
        .sc_loadclear_sequencer_CLOCK_50    (clk),
        .sc_loadclear_sequencer_RESET_InHigh(rst),
        .sc_loadclear_sequencer_clear_InLow (clrIn),
        .sc_loadclear_sequencer_load_InLow  (ldIn),
        .sc_loadclear_sequencer_clear_OutLow(clrOut),
        .sc_loadclear_sequencer_load_OutLow (ldOut),
        .sc_loadclear_sequencer_busy_Out    (busy),
        .sc_loadclear_sequencer_count_OutBUS(count)
    );

    function automatic bit repeatAge(input int a);
        return (a == HOLD + 1) || (a > HOLD + 1 && (a - HOLD - 1) % (REP + 1) == 0);
    endfunction

    task automatic modelReset();
        mMode = M_IDLE; mAge = 0; mPrevClr = 1'b1; mPrevLd = 1'b1;
        mClr = 1'b0; mLd = 1'b0; mCount = 8'd0;
    endtask

    // Advance the model over one rising edge using the inputs held across it.
    task automatic modelEdge();
        bit cf, lf, wasClr, wasLd;
        cf = mPrevClr && !clrIn;
        lf = mPrevLd && !ldIn;
        wasClr = mClr;
        wasLd = mLd;
        if (wasLd) mCount = mCount + 8'd1;
        else if (wasClr) mCount = 8'd0;
        mClr = 1'b0;
        mLd = 1'b0;
        if (cf && !wasClr) begin
            mClr = 1'b1;
            mMode = M_RELEASE;
        end else if (mMode == M_IDLE) begin
            if (lf) begin
                mLd = 1'b1;
                mAge = 0;
                mMode = AUTO ? M_PRESS : M_RELEASE;
            end
        end else if (mMode == M_RELEASE) begin
            if (!wasClr && !wasLd && clrIn && ldIn) mMode = M_IDLE;
        end else begin
            mAge = mAge + 1;
            if (!wasLd) begin
                if (ldIn) mMode = M_IDLE;
                else if (repeatAge(mAge)) mLd = 1'b1;
            end
        end
        mPrevClr = clrIn;
        mPrevLd = ldIn;
    endtask

    task automatic checkModel();
        vectors++;
        if (clrOut !== !mClr || ldOut !== !mLd || busy !== (mMode != M_IDLE) || count !== mCount) begin
            errs++;
            $display("FAIL model t=%0t clr/ld/busy/count got %b %b %b %02h expected %b %b %b %02h",
                     $time, clrOut, ldOut, busy, count, !mClr, !mLd, (mMode != M_IDLE), mCount);
        end
        if (clrOut === 1'b0) clrSeen++;
        if (ldOut === 1'b0) ldSeen++;
    endtask

    task automatic pin(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One clock: account for the edge just passed, compare, then drive new levels.
    task automatic step(input logic c, input logic l);
        @(negedge clk);
        if (rst) begin
            modelReset();
        end else begin
            modelEdge();
            checkModel();
        end
        clrIn = c;
        ldIn = l;
    endtask

    task automatic pressLoad();
        step(1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b1);
    endtask

    task automatic pressClear();
        step(1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b1);
    endtask

    initial begin
        logic rc, rl;
        modelReset();
        repeat (3) @(negedge clk);
        pin("reset clear", 32'(clrOut), 32'd1);
        pin("reset load", 32'(ldOut), 32'd1);
        pin("reset busy", 32'(busy), 32'd0);
        pin("reset count", 32'(count), 32'd0);
        rst = 1'b0;
        repeat (2) step(1'b1, 1'b1);

        // 3-cycle press: single strobe one edge after the fall, then count 1
        ldSeen = 0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        pin("first strobe low", 32'(ldOut), 32'd0);
        step(1'b1, 1'b0);
        pin("strobe width", 32'(ldOut), 32'd1);
        pin("count after press", 32'(count), 32'd1);
        pin("model count after press", 32'(mCount), 32'd1);
        repeat (3) step(1'b1, 1'b1);
        pin("single press strobes", 32'(ldSeen), 32'd1);

        // Simultaneous clear and load
        clrSeen = 0; ldSeen = 0;
        repeat (3) step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        pin("simul busy held", 32'(busy), 32'd1);
        step(1'b1, 1'b1);
        pin("simul busy released", 32'(busy), 32'd0);
        pin("simul clear strobes", 32'(clrSeen), 32'd1);
        pin("simul load strobes", 32'(ldSeen), 32'd0);
        pin("simul count", 32'(count), 32'd0);

        // Long hold: strobes at k, k+9, k+14, k+19 with auto-repeat
        pressClear();
        ldSeen = 0;
        repeat (21) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        pin("hold busy before release edge", 32'(busy), 32'd1);
        step(1'b1, 1'b1);
        pin("hold busy after release", 32'(busy), 32'd0);
        pin("hold strobes", 32'(ldSeen), AUTO ? 32'd4 : 32'd1);
        pin("hold count", 32'(count), AUTO ? 32'd4 : 32'd1);
        pin("model hold count", 32'(mCount), AUTO ? 32'd4 : 32'd1);

        // Wrap after 256 presses, then 3 more
        pressClear();
        repeat (256) pressLoad();
        pin("wrap count", 32'(count), 32'd0);
        repeat (3) pressLoad();
        pin("post-wrap count", 32'(count), 32'd3);

        // Clear while load is held
        repeat (4) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        clrSeen = 0; ldSeen = 0;
        repeat (15) step(1'b1, 1'b0);
        pin("clear-in-hold clear strobes", 32'(clrSeen), 32'd1);
        pin("clear-in-hold load strobes", 32'(ldSeen), 32'd0);
        pin("clear-in-hold count", 32'(count), 32'd0);
        repeat (3) step(1'b1, 1'b1);

        // Asynchronous reset during a held press, load kept low through reset
        pressClear();
        repeat (3) pressLoad();
        repeat (12) step(1'b1, 1'b0);
        pin("pre-reset count", 32'(count), AUTO ? 32'd5 : 32'd4);
        pin("pre-reset busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        pin("async reset clear", 32'(clrOut), 32'd1);
        pin("async reset load", 32'(ldOut), 32'd1);
        pin("async reset busy", 32'(busy), 32'd0);
        pin("async reset count", 32'(count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ldSeen = 0;
        step(1'b1, 1'b0);
        pin("held through reset strobe", 32'(ldOut), 32'd0);
        step(1'b1, 1'b1);
        repeat (3) step(1'b1, 1'b1);
        pin("held through reset strobes", 32'(ldSeen), 32'd1);

        // Random button activity
        rc = 1'b1; rl = 1'b1;
        repeat (3000) begin
            if ($urandom_range(0, 9) == 0) rl = ~rl;
            if (!rc) rc = ($urandom_range(0, 1) == 0);
            else if ($urandom_range(0, 39) == 0) rc = 1'b0;
            step(rc, rl);
        end
        repeat (4) step(1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
